store_drain_ctrl: RTL and testbench
===================================

// Module: store_drain_ctrl
// PURPOSE
//  Sequences retirement of committed stores from the write-back store queue to the single data-memory port.
//  - Counts stores committed by the ROB.
//  - Issues one read_en (store_valid) pulse per committed store.
//  - Arbitrates the memory port against load requests, with a starvation guard for stores.
//  - Defers a pipeline flush to the store queue until every committed store has drained, so no committed store is lost.
// PARAMETERS
//  FIFO_DEPTH    16  store queue depth; pending count never legally exceeds it
//  STARVE_LIMIT  4   consecutive cycles a store may lose to loads before it is forced to win
//  CNT_WIDTH     $clog2(FIFO_DEPTH)+1  pending counter width (derived, do not override)
// PORTS
//  clk           in   1  clock; one clock domain
//  rst           in   1  synchronous, active-high reset
//  commit_store  in   1  ROB retired one store this cycle
//  flush_req     in   1  pipeline flush request (1-cycle pulse)
//  sq_empty      in   1  store queue empty
//  mem_ready     in   1  memory port free this cycle
//  mem_wr_done   in   1  memory finished the outstanding write
//  load_req      in   1  load unit requests the memory port
//  load_grant    out  1  load owns the memory port this cycle (combinational)
//  store_valid   out  1  read_en to store queue; one pulse per drained store
//  sq_flush      out  1  flush to store queue (1-cycle pulse)
//  flush_busy    out  1  flush pending; front end must stall
//  pending_cnt   out  CNT_WIDTH  committed stores not yet issued
//  overflow_err  out  1  sticky: commit_store arrived while pending_cnt==FIFO_DEPTH
// BEHAVIOUR
//  Reset: all registered outputs 0, state IDLE, starve_cnt 0.
//   - rst has priority over every other input, including mid-WAIT_DONE; any outstanding write is abandoned.
//  pending_cnt:
//   - +1 on commit_store; -1 in the ISSUE cycle; both in the same cycle -> unchanged.
//   - Commit at FIFO_DEPTH: count holds and overflow_err is set; only rst clears overflow_err.
//  store_eligible = (state==IDLE) & pending_cnt!=0 & !sq_empty & mem_ready.
//  store_wins = store_eligible & (!load_req | starve_cnt>=STARVE_LIMIT | flush_busy).
//  load_grant = load_req & mem_ready & state==IDLE & !store_wins & !sq_flush_cycle.
//   - Loads are never granted outside IDLE.
//  starve_cnt:
//   - +1 on each cycle with store_eligible & !store_wins, saturating at STARVE_LIMIT.
//   - Cleared on ISSUE.
//  FSM (registered state):
//   - IDLE -> ISSUE when store_wins.
//   - IDLE, flush case: flush_busy & pending_cnt==0 -> sq_flush=1 for one cycle, flush_busy cleared the next cycle.
//     - The flush is checked before store_wins (store_wins is false because pending_cnt==0).
//   - ISSUE -> WAIT_DONE: store_valid=1 for exactly this one cycle; pending_cnt decrements.
//   - WAIT_DONE -> IDLE: on mem_wr_done; store_valid=0 throughout.
//     - mem_wr_done outside WAIT_DONE is ignored.
//  Flush:
//   - flush_req sets flush_busy the next cycle; flush_req while flush_busy=1 is ignored.
//   - Commits in the flush_req cycle or while flush_busy=1 are counted and drained before sq_flush.
//   - sq_flush never coincides with store_valid, and is never issued in ISSUE or WAIT_DONE.
//  pending_cnt!=0 with sq_empty=1 (write-back lag): wait; no pulse.
//  Store throughput: at most one store every 3 cycles (IDLE, ISSUE, WAIT_DONE, with done returned immediately).
// TESTING
//  1. Three commit_store pulses, mem_ready=1, no loads, done 1 cycle after each issue
//     -> 3 store_valid pulses spaced 3 cycles apart; pending_cnt 3->0.
//  2. pending_cnt=2, load_req held high, STARVE_LIMIT=4
//     -> load_grant for 4 cycles, then store_valid; starve_cnt clears; load_grant=0 until IDLE.
//  3. pending_cnt=2 and flush_req
//     -> flush_busy=1 next cycle; both stores drain; sq_flush one cycle after the 2nd return to IDLE;
//        flush_busy=0 the cycle after.
//  4. commit_store and ISSUE in the same cycle at pending_cnt=1
//     -> pending_cnt stays 1; a further 17 commits with no drain -> pending_cnt=16, overflow_err=1.
//  5. rst asserted in WAIT_DONE with pending_cnt=5, flush_busy=1
//     -> next cycle: state IDLE, all outputs 0, no sq_flush, no store_valid.
//  6. pending_cnt=1, sq_empty=1 for 4 cycles, then 0
//     -> no store_valid while empty; single pulse after sq_empty falls; loads granted meanwhile.

Source files
------------

// File: rtl/store_drain_ctrl.sv
// store_drain_ctrl: retires committed stores from the write-back store queue
// to the single data-memory port. It counts ROB store commits, issues one
// store_valid pulse per drained store, and arbitrates the port against loads.
// A store that keeps losing to loads is eventually forced to win. A pipeline
// flush is held back until every committed store has left the queue.
//
// Handshake: store_valid is a single-cycle read_en to the store queue, raised
// only in ISSUE. The controller then waits in WAIT_DONE until the memory
// answers with mem_wr_done. A mem_wr_done seen in any other state is ignored.
// Arbitration is decided only in IDLE, and only when mem_ready is high.
module store_drain_ctrl #(
  parameter int FIFO_DEPTH   = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_store,
  input  logic                 flush_req,
  input  logic                 sq_empty,
  input  logic                 mem_ready,
  input  logic                 mem_wr_done,
  input  logic                 load_req,
  output logic                 load_grant,
  output logic                 store_valid,
  output logic                 sq_flush,
  output logic                 flush_busy,
  output logic [CNT_WIDTH-1:0] pending_cnt,
  output logic                 overflow_err,
  output logic [1:0]           dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] DEPTH_MAX  = CNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 flush_busy_q, flush_busy_d;
  logic                 overflow_q, overflow_d;

  logic in_idle;
  logic in_issue;
  logic store_eligible;
  logic store_wins;
  logic flush_fire;

  // Arbitration terms. While a flush is pending, stores win outright so the
  // flush is not delayed by loads.
  always_comb begin
    in_idle        = (state_q == S_IDLE);
    in_issue       = (state_q == S_ISSUE);
    store_eligible = in_idle && (pend_q != '0) && !sq_empty && mem_ready;
    store_wins     = store_eligible &&
                     (!load_req || (starve_q >= STARVE_MAX) || flush_busy_q);
    // pend_q==0 keeps store_wins low here, so the flush never competes with a store.
    flush_fire     = in_idle && flush_busy_q && (pend_q == '0);
  end

  // Next-state logic for the drain FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (store_wins) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mem_wr_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pending counter, overflow flag, starvation counter and flush tracking.
  always_comb begin
    pend_d       = pend_q;
    overflow_d   = overflow_q;
    starve_d     = starve_q;
    flush_busy_d = flush_busy_q;

    // The count saturates at the queue depth. A commit arriving at the depth
    // is reported through the sticky overflow flag.
    if (commit_store && !in_issue) begin
      if (pend_q == DEPTH_MAX) overflow_d = 1'b1;
      else                     pend_d     = pend_q + CNT_WIDTH'(1);
    end else if (!commit_store && in_issue) begin
      pend_d = pend_q - CNT_WIDTH'(1);
    end
    if (commit_store && in_issue && (pend_q == DEPTH_MAX)) overflow_d = 1'b1;

    if (in_issue) starve_d = '0;
    else if (store_eligible && !store_wins && (starve_q < STARVE_MAX))
      starve_d = starve_q + SW'(1);

    if (flush_fire)                         flush_busy_d = 1'b0;
    else if (flush_req && !flush_busy_q)    flush_busy_d = 1'b1;
  end

  // State registers. Reset overrides everything, including an outstanding write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      starve_q     <= '0;
      flush_busy_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      starve_q     <= starve_d;
      flush_busy_q <= flush_busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Output drive.
  always_comb begin
    load_grant   = load_req && mem_ready && in_idle && !store_wins && !flush_fire;
    store_valid  = in_issue;
    sq_flush     = flush_fire;
    flush_busy   = flush_busy_q;
    pending_cnt  = pend_q;
    overflow_err = overflow_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl with hand-computed per-cycle expectations.
module tb_store_drain_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       commit_store, flush_req, sq_empty, mem_ready, mem_wr_done, load_req;
  logic       load_grant, store_valid, sq_flush, flush_busy, overflow_err;
  logic [4:0] pending_cnt;
  logic [1:0] dbg_state;

  store_drain_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .commit_store (commit_store),
    .flush_req    (flush_req),
    .sq_empty     (sq_empty),
    .mem_ready    (mem_ready),
    .mem_wr_done  (mem_wr_done),
    .load_req     (load_req),
    .load_grant   (load_grant),
    .store_valid  (store_valid),
    .sq_flush     (sq_flush),
    .flush_busy   (flush_busy),
    .pending_cnt  (pending_cnt),
    .overflow_err (overflow_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are applied just after a rising edge; outputs are sampled 1ns later.
  task automatic drive(input logic c, input logic f, input logic e,
                       input logic r, input logic d, input logic l);
    commit_store = c;
    flush_req    = f;
    sq_empty     = e;
    mem_ready    = r;
    mem_wr_done  = d;
    load_req     = l;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- expected tables ----------------
  // Bit k of each vector is the expected value in cycle k of that scenario.
  logic [10:0] t1_sv   = 11'b00100100100;
  int          t1_pend [11] = '{0, 1, 2, 2, 2, 2, 1, 1, 1, 0, 0};
  logic [7:0]  t2_lg   = 8'b10001111;
  logic [7:0]  t2_sv   = 8'b00100000;
  int          t2_st   [8] = '{0, 0, 0, 0, 0, 1, 2, 0};
  logic [7:0]  t3_fb   = 8'b01111110;
  logic [7:0]  t3_sqf  = 8'b01000000;
  logic [7:0]  t3_sv   = 8'b00010010;
  logic [7:0]  t3_lg   = 8'b10000000;
  logic [7:0]  t6_sv   = 8'b00100000;
  logic [7:0]  t6_lg   = 8'b00001111;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset.
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    check_val("rst_pend",  int'(pending_cnt),  0);
    check_val("rst_ovf",   int'(overflow_err), 0);
    check_val("rst_fbusy", int'(flush_busy),   0);
    check_val("rst_sv",    int'(store_valid),  0);
    check_val("rst_sqf",   int'(sq_flush),     0);
    check_val("rst_state", int'(dbg_state),    0);
    next_cycle();

    // 1: three commits, done held high -> pulses every 3 cycles.
    for (int k = 0; k < 11; k++) begin
      drive(k < 3, 0, 0, 1, 1, 0);
      check_val($sformatf("t1_sv_%0d", k),   int'(store_valid), int'(t1_sv[k]));
      check_val($sformatf("t1_pend_%0d", k), int'(pending_cnt), t1_pend[k]);
      next_cycle();
    end

    // 2: starvation guard with load_req held high.
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 1, 0);
      next_cycle();
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 1, 1, 1);
      check_val($sformatf("t2_lg_%0d", k), int'(load_grant),  int'(t2_lg[k]));
      check_val($sformatf("t2_sv_%0d", k), int'(store_valid), int'(t2_sv[k]));
      check_val($sformatf("t2_st_%0d", k), int'(dbg_state),   t2_st[k]);
      next_cycle();
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 1, 1, 0);
      next_cycle();
    end
    check_val("t2_drain_pend",  int'(pending_cnt), 0);
    check_val("t2_drain_state", int'(dbg_state),   0);

    // 3: flush deferred until both pending stores drain.
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 1, 0);
      next_cycle();
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, k == 0, 0, 1, 1, k >= 6);
      check_val($sformatf("t3_fb_%0d", k),  int'(flush_busy),  int'(t3_fb[k]));
      check_val($sformatf("t3_sqf_%0d", k), int'(sq_flush),    int'(t3_sqf[k]));
      check_val($sformatf("t3_sv_%0d", k),  int'(store_valid), int'(t3_sv[k]));
      check_val($sformatf("t3_lg_%0d", k),  int'(load_grant),  int'(t3_lg[k]));
      next_cycle();
    end

    // 4: commit in the ISSUE cycle, then fill to the depth and overflow.
    drive(1, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check_val("t4_issue_sv", int'(store_valid), 1);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check_val("t4_same_pend",  int'(pending_cnt), 1);
    check_val("t4_same_state", int'(dbg_state),   2);
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, 0, 1, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 0);
    check_val("t4_full_pend", int'(pending_cnt),  16);
    check_val("t4_full_ovf",  int'(overflow_err), 0);
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 1, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 0);
    check_val("t4_ovf_pend", int'(pending_cnt),  16);
    check_val("t4_ovf_flag", int'(overflow_err), 1);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check_val("t4_ovf_sticky", int'(overflow_err), 1);

    // 5: reset in WAIT_DONE with pending_cnt=5 and flush_busy=1.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    check_val("t5_rst_ovf",  int'(overflow_err), 0);
    check_val("t5_rst_pend", int'(pending_cnt),  0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(1, k == 0, 0, 0, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 0);
    check_val("t5_pre_pend",  int'(pending_cnt), 5);
    check_val("t5_pre_fbusy", int'(flush_busy),  1);
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check_val("t5_issue_sv", int'(store_valid), 1);
    next_cycle();
    drive(0, 0, 0, 1, 1, 0);
    rst = 1'b1;
    check_val("t5_wait_state", int'(dbg_state),   2);
    check_val("t5_wait_pend",  int'(pending_cnt), 5);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 1, 1, 0);
    check_val("t5_post_state", int'(dbg_state),    0);
    check_val("t5_post_pend",  int'(pending_cnt),  0);
    check_val("t5_post_fbusy", int'(flush_busy),   0);
    check_val("t5_post_sv",    int'(store_valid),  0);
    check_val("t5_post_sqf",   int'(sq_flush),     0);
    check_val("t5_post_ovf",   int'(overflow_err), 0);
    next_cycle();
    drive(0, 0, 0, 1, 1, 0);
    check_val("t5_post2_sv",  int'(store_valid), 0);
    check_val("t5_post2_sqf", int'(sq_flush),    0);
    next_cycle();

    // 6: write-back lag (sq_empty) blocks the store; loads proceed.
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, 0, k < 4, 1, 1, k < 4);
      check_val($sformatf("t6_sv_%0d", k), int'(store_valid), int'(t6_sv[k]));
      check_val($sformatf("t6_lg_%0d", k), int'(load_grant),  int'(t6_lg[k]));
      next_cycle();
    end
    drive(0, 0, 0, 1, 1, 0);
    check_val("t6_end_pend", int'(pending_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
